// File: rtl/msrv_32_writeback_unit.sv
// Integer register file writeback arbiter for the msrv_32 core.
// Merges single-cycle ALU results with one outstanding data-memory load,
// extends load data by width/sign, and aborts loads that never return.
module msrv_32_writeback_unit #(
  parameter int unsigned LD_TIMEOUT = 16
) (
  input  logic        ms_risc32_mp_clk_in,
  input  logic        ms_risc32_mp_rst_in,
  input  logic        alu_valid_in,
  input  logic [4:0]  alu_rd_addr_in,
  input  logic [31:0] alu_result_in,
  input  logic        ld_issue_in,
  input  logic [4:0]  ld_rd_addr_in,
  input  logic [2:0]  ld_funct3_in,
  input  logic [1:0]  ld_addr_lsb_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        wr_en_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_out,
  output logic        ld_busy_out,
  output logic        stall_out,
  output logic        ld_err_out
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t      r_state;
  logic [7:0]  r_count;
  logic        r_busy;
  logic        r_err;
  logic [4:0]  r_ld_rd;
  logic [2:0]  r_ld_funct3;
  logic [1:0]  r_ld_lsb;
  logic        r_ld_cancel;

  logic        r_skid_valid;
  logic [4:0]  r_skid_rd;
  logic [31:0] r_skid_data;

  logic        r_wr_en;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data;

  logic        w_ld_resp;
  logic        w_alu_accept;
  logic        w_skid_load;
  logic        w_alu_direct;
  logic        w_waw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  // Event decode: a response only counts while a load is outstanding, and the
  // ALU is only accepted when the skid entry is free.
  always_comb begin
    w_ld_resp    = (r_state == ST_WAIT) && dmem_rvalid_in;
    w_alu_accept = alu_valid_in && !r_skid_valid;
    w_skid_load  = w_ld_resp && w_alu_accept;
    w_alu_direct = !w_ld_resp && w_alu_accept;
    w_waw        = (r_state == ST_WAIT) && w_alu_direct && (alu_rd_addr_in == r_ld_rd);
  end

  // Select the addressed byte/half of the response and extend it per funct3.
  always_comb begin
    w_byte    = 8'h00;
    w_half    = 16'h0000;
    w_ld_data = dmem_rdata_in;
    case (r_ld_lsb)
      2'd0:    w_byte = dmem_rdata_in[7:0];
      2'd1:    w_byte = dmem_rdata_in[15:8];
      2'd2:    w_byte = dmem_rdata_in[23:16];
      default: w_byte = dmem_rdata_in[31:24];
    endcase
    w_half = r_ld_lsb[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    case (r_ld_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'h000000, w_byte};
      3'b101:  w_ld_data = {16'h0000, w_half};
      default: w_ld_data = dmem_rdata_in;
    endcase
  end

  // Load tracking FSM: capture on issue, retire on response or timeout.
  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      r_state     <= ST_IDLE;
      r_count     <= 8'd0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_ld_rd     <= 5'd0;
      r_ld_funct3 <= 3'd0;
      r_ld_lsb    <= 2'd0;
      r_ld_cancel <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ld_issue_in) begin
            r_state     <= ST_WAIT;
            r_busy      <= 1'b1;
            r_count     <= 8'd0;
            r_ld_rd     <= ld_rd_addr_in;
            r_ld_funct3 <= ld_funct3_in;
            r_ld_lsb    <= ld_addr_lsb_in;
            r_ld_cancel <= 1'b0;
          end
        end
        default: begin
          if (w_waw) begin
            r_ld_cancel <= 1'b1;
          end
          if (dmem_rvalid_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_count == 8'(LD_TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
      endcase
    end
  end

  // One-entry skid holding an ALU result that lost to a load response.
  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      r_skid_valid <= 1'b0;
      r_skid_rd    <= 5'd0;
      r_skid_data  <= 32'd0;
    end else if (r_skid_valid) begin
      r_skid_valid <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_valid <= 1'b1;
      r_skid_rd    <= alu_rd_addr_in;
      r_skid_data  <= alu_result_in;
    end
  end

  // Write port: load response beats skid beats ALU; x0 writes are dropped.
  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      r_wr_en   <= 1'b0;
      r_rd_addr <= 5'd0;
      r_rd_data <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_ld_resp) begin
        if (!r_ld_cancel && (r_ld_rd != 5'd0)) begin
          r_wr_en   <= 1'b1;
          r_rd_addr <= r_ld_rd;
          r_rd_data <= w_ld_data;
        end
      end else if (r_skid_valid) begin
        if (r_skid_rd != 5'd0) begin
          r_wr_en   <= 1'b1;
          r_rd_addr <= r_skid_rd;
          r_rd_data <= r_skid_data;
        end
      end else if (w_alu_direct) begin
        if (alu_rd_addr_in != 5'd0) begin
          r_wr_en   <= 1'b1;
          r_rd_addr <= alu_rd_addr_in;
          r_rd_data <= alu_result_in;
        end
      end
    end
  end

  assign wr_en_out   = r_wr_en;
  assign rd_addr_out = r_rd_addr;
  assign rd_out      = r_rd_data;
  assign ld_busy_out = r_busy;
  assign ld_err_out  = r_err;
  assign stall_out   = r_skid_valid || ((r_state == ST_WAIT) && ld_issue_in);

endmodule

// File: tb/tb_msrv_32_writeback_unit.sv
// Self-checking bench for msrv_32_writeback_unit: directed vector table,
// timeout sequence, and randomized traffic against a behavioural model.
module tb_msrv_32_writeback_unit;

  localparam int TMO = 16;

  typedef struct {
    bit          rst;
    bit          alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_res;
    bit          ld_iss;
    logic [4:0]  ld_rd;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    bit          rv;
    logic [31:0] rdata;
  } in_t;

  typedef struct {
    in_t         in;
    bit          e_stall;
    bit          e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    bit          e_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_res;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_lsb;
  logic        rvalid;
  logic [31:0] rdata;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Model state: what is outstanding, what the register file port last saw.
  bit          m_pending;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lsb;
  int          m_age;
  bit          m_cancel;
  wr_t         m_skid[$];
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_rdo;
  logic [31:0] m_dato;

  vec_t tbl[$];

  msrv_32_writeback_unit #(.LD_TIMEOUT(TMO)) dut (
    .ms_risc32_mp_clk_in(clk),
    .ms_risc32_mp_rst_in(rst),
    .alu_valid_in(alu_valid),
    .alu_rd_addr_in(alu_rd),
    .alu_result_in(alu_res),
    .ld_issue_in(ld_issue),
    .ld_rd_addr_in(ld_rd),
    .ld_funct3_in(ld_f3),
    .ld_addr_lsb_in(ld_lsb),
    .dmem_rvalid_in(rvalid),
    .dmem_rdata_in(rdata),
    .wr_en_out(wr_en),
    .rd_addr_out(rd_addr),
    .rd_out(rd_data),
    .ld_busy_out(busy),
    .stall_out(stall),
    .ld_err_out(err)
  );

  always #5 clk = ~clk;

  function automatic in_t mkIn(bit r, bit av, logic [4:0] ard, logic [31:0] ares,
                               bit li, logic [4:0] lrd, logic [2:0] f3, logic [1:0] lsb,
                               bit rv, logic [31:0] rd);
    in_t s;
    s.rst = r; s.alu_v = av; s.alu_rd = ard; s.alu_res = ares;
    s.ld_iss = li; s.ld_rd = lrd; s.f3 = f3; s.lsb = lsb;
    s.rv = rv; s.rdata = rd;
    return s;
  endfunction

  function automatic vec_t mkVec(in_t s, bit es, bit ewe, logic [4:0] erd,
                                 logic [31:0] edat, bit eb);
    vec_t v;
    v.in = s; v.e_stall = es; v.e_we = ewe; v.e_rd = erd; v.e_data = edat; v.e_busy = eb;
    return v;
  endfunction

  function automatic logic [31:0] extLoad(logic [2:0] f3, logic [1:0] lsb, logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * lsb));
    h = 16'(d >> (16 * lsb[1]));
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void modelWrite(logic [4:0] r, logic [31:0] d);
    if (r != 5'd0) begin
      m_we = 1'b1; m_rdo = r; m_dato = d;
    end
  endfunction

  // Advance the behavioural model by one clock with the given inputs.
  function automatic void modelStep(in_t s);
    bit resp;
    wr_t e;
    if (s.rst) begin
      m_pending = 0; m_skid.delete(); m_err = 0;
      m_we = 0; m_rdo = 5'd0; m_dato = 32'd0;
      return;
    end
    m_we = 0;
    resp = m_pending && s.rv;
    if (resp) begin
      if (!m_cancel) modelWrite(m_rd, extLoad(m_f3, m_lsb, s.rdata));
      if (s.alu_v && m_skid.size() == 0) begin
        e.rd = s.alu_rd; e.data = s.alu_res;
        m_skid.push_back(e);
      end
    end else if (m_skid.size() > 0) begin
      e = m_skid.pop_front();
      modelWrite(e.rd, e.data);
    end else if (s.alu_v) begin
      modelWrite(s.alu_rd, s.alu_res);
      if (m_pending && s.alu_rd == m_rd) m_cancel = 1;
    end
    if (m_pending) begin
      if (resp) m_pending = 0;
      else begin
        m_age++;
        if (m_age >= TMO) begin
          m_pending = 0; m_err = 1;
        end
      end
    end else if (s.ld_iss) begin
      m_pending = 1; m_rd = s.ld_rd; m_f3 = s.f3; m_lsb = s.lsb;
      m_age = 0; m_cancel = 0;
    end
  endfunction

  // Drive one cycle of inputs, check the combinational stall, clock, settle.
  task automatic applyStimulus(input in_t s);
    bit exp_stall;
    rst = s.rst; alu_valid = s.alu_v; alu_rd = s.alu_rd; alu_res = s.alu_res;
    ld_issue = s.ld_iss; ld_rd = s.ld_rd; ld_f3 = s.f3; ld_lsb = s.lsb;
    rvalid = s.rv; rdata = s.rdata;
    #2;
    exp_stall = (m_skid.size() != 0) || (m_pending && s.ld_iss);
    chk("stall_model", 32'(stall), 32'(exp_stall));
    modelStep(s);
    @(posedge clk);
    #1;
  endtask

  // Compare registered outputs against the model.
  task automatic checkOutput();
    chk("wr_en_model", 32'(wr_en), 32'(m_we));
    chk("rd_addr_model", 32'(rd_addr), 32'(m_rdo));
    chk("rd_out_model", rd_data, m_dato);
    chk("busy_model", 32'(busy), 32'(m_pending));
    chk("err_model", 32'(err), 32'(m_err));
  endtask

  in_t idle;
  in_t rs;
  in_t s;
  bit  slow;

  initial begin
    idle = mkIn(0, 0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 0, 32'd0);
    rs   = idle; rs.rst = 1;

    // Directed vectors, one row per cycle, starting from reset.
    tbl.push_back(mkVec(mkIn(0,1,5'd5,32'hDEADBEEF,0,5'd0,3'd0,2'd0,0,32'd0),        0,1,5'd5,32'hDEADBEEF,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd7,3'b000,2'd2,0,32'd0),             0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(idle,                                                        0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(idle,                                                        0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'h12803456),        0,1,5'd7,32'hFFFFFF80,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd4,3'b101,2'd0,0,32'd0),             0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(0,1,5'd3,32'h11,0,5'd0,3'd0,2'd0,1,32'h0000F00D),       0,1,5'd4,32'h0000F00D,0));
    tbl.push_back(mkVec(idle,                                                        1,1,5'd3,32'h00000011,0));
    tbl.push_back(mkVec(mkIn(0,1,5'd0,32'h99,0,5'd0,3'd0,2'd0,0,32'd0),              0,0,5'd0,32'd0,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd9,3'b010,2'd0,0,32'd0),             0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(0,1,5'd9,32'h55,0,5'd0,3'd0,2'd0,0,32'd0),              0,1,5'd9,32'h00000055,1));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd1,3'b010,2'd0,0,32'd0),             1,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'hCAFEF00D),        0,0,5'd0,32'd0,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'h00000001),        0,0,5'd0,32'd0,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd2,3'b001,2'd2,0,32'd0),             0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'h80011234),        0,1,5'd2,32'hFFFF8001,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd6,3'b100,2'd3,0,32'd0),             0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'hF0000000),        0,1,5'd6,32'h000000F0,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd8,3'b111,2'd1,0,32'd0),             0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'h89ABCDEF),        0,1,5'd8,32'h89ABCDEF,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,1,5'd10,3'b000,2'd0,0,32'd0),            0,0,5'd0,32'd0,1));
    tbl.push_back(mkVec(mkIn(1,1,5'd12,32'h77,0,5'd0,3'd0,2'd0,1,32'h000000FF),      0,0,5'd0,32'd0,0));
    tbl.push_back(mkVec(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'h000000FF),        0,0,5'd0,32'd0,0));

    // Power-up reset: first edge brings state out of X, second is checked.
    rst = 1; alu_valid = 0; alu_rd = 0; alu_res = 0; ld_issue = 0; ld_rd = 0;
    ld_f3 = 0; ld_lsb = 0; rvalid = 0; rdata = 0;
    @(posedge clk); #1;
    modelStep(rs);
    applyStimulus(rs);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_rd_out", rd_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    checkOutput();

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].in);
      checkOutput();
      chk($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
      if (tbl[i].e_we || tbl[i].in.rst) begin
        chk($sformatf("tbl%0d_rd_addr", i), 32'(rd_addr), 32'(tbl[i].e_rd));
        chk($sformatf("tbl%0d_rd_out", i), rd_data, tbl[i].e_data);
      end
    end
    // Stall is combinational: verify the skid-full row separately from the model.
    chk("tbl_stall_rows", 32'(tbl[7].e_stall && tbl[11].e_stall), 32'(1));

    // Timeout: no response for TMO cycles aborts the load and latches the error.
    applyStimulus(rs); checkOutput();
    applyStimulus(mkIn(0,0,5'd0,32'd0,1,5'd11,3'b010,2'd0,0,32'd0)); checkOutput();
    for (int k = 1; k <= TMO; k++) begin
      applyStimulus(idle);
      checkOutput();
      chk($sformatf("tmo_busy_%0d", k), 32'(busy), 32'(k < TMO));
      chk($sformatf("tmo_err_%0d", k), 32'(err), 32'(k >= TMO));
      chk($sformatf("tmo_wr_en_%0d", k), 32'(wr_en), 32'd0);
    end
    applyStimulus(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'h12345678)); checkOutput();
    chk("tmo_late_rvalid", 32'(wr_en), 32'd0);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    applyStimulus(mkIn(0,0,5'd0,32'd0,1,5'd13,3'b010,2'd0,0,32'd0)); checkOutput();
    applyStimulus(mkIn(0,0,5'd0,32'd0,0,5'd0,3'd0,2'd0,1,32'hA5A5A5A5)); checkOutput();
    chk("post_tmo_load_we", 32'(wr_en), 32'd1);
    chk("post_tmo_load_data", rd_data, 32'hA5A5A5A5);
    chk("post_tmo_err_held", 32'(err), 32'd1);
    applyStimulus(rs); checkOutput();
    chk("reset_clears_err", 32'(err), 32'd0);

    // Randomized traffic, alternating fast and slow memory phases.
    for (int i = 0; i < 3000; i++) begin
      slow = ((i / 400) % 2) == 1;
      s.rst     = ($urandom_range(0, 99) == 0);
      s.alu_v   = 1'($urandom_range(0, 1));
      s.alu_rd  = 5'($urandom_range(0, 3));
      s.alu_res = $urandom;
      s.ld_iss  = ($urandom_range(0, 2) == 0);
      s.ld_rd   = 5'($urandom_range(0, 3));
      s.f3      = 3'($urandom_range(0, 7));
      s.lsb     = 2'($urandom_range(0, 3));
      s.rv      = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      s.rdata   = $urandom;
      applyStimulus(s);
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
